alu_seq: RTL and testbench

Parametrised sequential ALU: the next generation of the 8-bit datapath ALU for the 6502 soft core and wider derivatives. It performs single-cycle arithmetic, logic, shift and rotate operations, and a multi-cycle unsigned shift-add multiply, all under a START/BUSY/DONE handshake. Results and the C/V/N/Z status flags are registered inside the block, with per-flag write enables and an external flag load for PLP/RTI. It sits between the instruction decoder and the register file.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_mul.sv | 64 ++++++
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcodes, {C,V,N,Z} flag bit positions and FSM states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OpAdc  = 4'd0,
        OpSbc  = 4'd1,
        OpCmp  = 4'd2,
        OpAnd  = 4'd3,
        OpOr   = 4'd4,
        OpXor  = 4'd5,
        OpNot  = 4'd6,
        OpAsl  = 4'd7,
        OpLsr  = 4'd8,
        OpAsr  = 4'd9,
        OpRol  = 4'd10,
        OpRor  = 4'd11,
        OpInc  = 4'd12,
        OpDec  = 4'd13,
        OpPass = 4'd14,
        OpMul  = 4'd15
    } alu_op_e;

    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagV = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagZ = 0;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StMulRun = 1'b1;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// o_done/o_prod are valid on the cycle whose closing edge retires the final bit.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    import alu_seq_pkg::*;

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic             r_run;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // r_lo holds the unconsumed multiplier bits and collects product LSBs from the top.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end

    assign o_prod = {w_hi_nxt, w_lo_nxt};
    assign o_done = r_run && (r_cnt == CntLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= i_mcand;
            r_hi    <= '0;
            r_lo    <= i_mplier;
        end else if (r_run) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an iterative multiply,
// with registered result and C/V/N/Z flags behind a START/BUSY/DONE handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_flag_we,
    input  logic             i_load_flags,
    input  logic [3:0]       i_flags_in,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_yh,
    output logic             o_c,
    output logic             o_v,
    output logic             o_n,
    output logic             o_z,
    output logic             o_busy,
    output logic             o_done
);
    import alu_seq_pkg::*;

    localparam int unsigned Msb = WIDTH - 1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_yh;
    logic [3:0]       r_flags;
    logic [3:0]       r_mul_we;
    logic             r_done;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_alu_go;
    logic             w_mul_go;
    logic             w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_b_add;
    logic             w_c_add;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH-1:0] w_res;
    logic             w_c_new;
    logic             w_v_new;
    logic [3:0]       w_aff;
    logic             w_wr_y;
    logic [3:0]       w_alu_flags;
    logic [3:0]       w_mul_flags;
    logic [3:0]       w_flags_nxt;

    assign w_op     = alu_op_e'(i_op);
    assign w_accept = i_start && (r_state == StIdle);
    assign w_alu_go = w_accept && (w_op != OpMul);
    assign w_mul_go = w_accept && (w_op == OpMul);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_mul_go),
        .i_mcand  (i_a),
        .i_mplier (i_b),
        .o_done   (w_mul_done),
        .o_prod   (w_mul_prod)
    );

    // SBC and CMP share the ADC adder with B inverted; CMP forces carry-in high.
    always_comb begin
        w_b_add = (w_op == OpAdc) ? i_b : ~i_b;
        w_c_add = (w_op == OpCmp) ? 1'b1 : r_flags[FlagC];
        w_sum   = {1'b0, i_a} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_c_add};
        w_add_v = (i_a[Msb] == w_b_add[Msb]) && (w_sum[Msb] != i_a[Msb]);

        w_res   = i_a;
        w_c_new = r_flags[FlagC];
        w_v_new = r_flags[FlagV];
        w_aff   = 4'b0011;
        w_wr_y  = 1'b1;
        case (w_op)
            OpAdc, OpSbc: begin
                w_res   = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = w_add_v;
                w_aff   = 4'b1111;
            end
            OpCmp: begin
                w_res   = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = w_add_v;
                w_aff   = 4'b1111;
                w_wr_y  = 1'b0;
            end
            OpAnd:  w_res = i_a & i_b;
            OpOr:   w_res = i_a | i_b;
            OpXor:  w_res = i_a ^ i_b;
            OpNot:  w_res = ~i_a;
            OpAsl: begin
                w_res   = {i_a[Msb-1:0], 1'b0};
                w_c_new = i_a[Msb];
                w_aff   = 4'b1011;
            end
            OpLsr: begin
                w_res   = {1'b0, i_a[Msb:1]};
                w_c_new = i_a[0];
                w_aff   = 4'b1011;
            end
            OpAsr: begin
                w_res   = {i_a[Msb], i_a[Msb:1]};
                w_c_new = i_a[0];
                w_aff   = 4'b1011;
            end
            OpRol: begin
                w_res   = {i_a[Msb-1:0], r_flags[FlagC]};
                w_c_new = i_a[Msb];
                w_aff   = 4'b1011;
            end
            OpRor: begin
                w_res   = {r_flags[FlagC], i_a[Msb:1]};
                w_c_new = i_a[0];
                w_aff   = 4'b1011;
            end
            OpInc:  w_res = i_a + WIDTH'(1);
            OpDec:  w_res = i_a - WIDTH'(1);
            OpPass: w_res = i_a;
            default: ;
        endcase

        w_alu_flags        = r_flags;
        w_alu_flags[FlagC] = w_c_new;
        w_alu_flags[FlagV] = w_v_new;
        w_alu_flags[FlagN] = w_res[Msb];
        w_alu_flags[FlagZ] = (w_res == '0);
    end

    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FlagC] = (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[FlagN] = w_mul_prod[2*WIDTH-1];
        w_mul_flags[FlagZ] = (w_mul_prod == '0);

        w_flags_nxt = r_flags;
        if (i_load_flags) begin
            w_flags_nxt = i_flags_in;
        end else if (w_mul_done) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mul_we[i]) w_flags_nxt[i] = w_mul_flags[i];
            end
        end else if (w_alu_go) begin
            for (int i = 0; i < 4; i++) begin
                if (i_flag_we[i] && w_aff[i]) w_flags_nxt[i] = w_alu_flags[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_y      <= '0;
            r_yh     <= '0;
            r_flags  <= '0;
            r_mul_we <= '0;
            r_done   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_done  <= w_alu_go || w_mul_done;
            if (w_mul_go) begin
                r_state  <= StMulRun;
                r_mul_we <= i_flag_we;
            end else if (w_mul_done) begin
                r_state <= StIdle;
            end
            if (w_mul_done) begin
                r_y  <= w_mul_prod[WIDTH-1:0];
                r_yh <= w_mul_prod[2*WIDTH-1:WIDTH];
            end else if (w_alu_go && w_wr_y) begin
                r_y  <= w_res;
                r_yh <= '0;
            end
        end
    end

    assign o_y    = r_y;
    assign o_yh   = r_yh;
    assign o_c    = r_flags[FlagC];
    assign o_v    = r_flags[FlagV];
    assign o_n    = r_flags[FlagN];
    assign o_z    = r_flags[FlagZ];
    assign o_busy = (r_state == StMulRun);
    assign o_done = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an arithmetic reference model checked every cycle, plus directed
// vectors with literal expectations at WIDTH=8 and one wide multiply at WIDTH=16.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [3:0] flag_we;
    logic       load_flags;
    logic [3:0] flags_in;
    logic [7:0] y, yh;
    logic       c, v, n, z, busy, done;
    logic [3:0] flags;

    logic        start16;
    logic [15:0] a16, b16, y16, yh16;
    logic        c16, v16, n16, z16, busy16, done16;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    assign flags = {c, v, n, z};

    alu_seq #(.WIDTH(8)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_a          (a),
        .i_b          (b),
        .i_flag_we    (flag_we),
        .i_load_flags (load_flags),
        .i_flags_in   (flags_in),
        .o_y          (y),
        .o_yh         (yh),
        .o_c          (c),
        .o_v          (v),
        .o_n          (n),
        .o_z          (z),
        .o_busy       (busy),
        .o_done       (done)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start16),
        .i_op         (4'hF),
        .i_a          (a16),
        .i_b          (b16),
        .i_flag_we    (4'hF),
        .i_load_flags (1'b0),
        .i_flags_in   (4'h0),
        .o_y          (y16),
        .o_yh         (yh16),
        .o_c          (c16),
        .o_v          (v16),
        .o_n          (n16),
        .o_z          (z16),
        .o_busy       (busy16),
        .o_done       (done16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference semantics for one non-multiply op on 8-bit operands, in plain integers.
    function automatic void model_op(input logic [3:0] o, input logic [7:0] ai, input logic [7:0] bi,
                                     input logic cin, output logic [7:0] res,
                                     output logic [3:0] nf, output logic [3:0] aff,
                                     output logic wr);
        int ua, ub, sa, sb, r, ci, sr;
        logic cy, ov;
        ua = int'(ai);
        ub = int'(bi);
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        ci = cin ? 1 : 0;
        r = ua; cy = cin; ov = 1'b0; aff = 4'b0011; wr = 1'b1;
        case (o)
            4'd0: begin
                r = ua + ub + ci; cy = (r > 255);
                sr = sa + sb + ci; ov = (sr > 127) || (sr < -128); aff = 4'b1111;
            end
            4'd1, 4'd2: begin
                if (o == 4'd2) begin ci = 1; wr = 1'b0; end
                r = ua - ub - (1 - ci); cy = (r >= 0);
                sr = sa - sb - (1 - ci); ov = (sr > 127) || (sr < -128); aff = 4'b1111;
            end
            4'd3:  r = int'(ai & bi);
            4'd4:  r = int'(ai | bi);
            4'd5:  r = int'(ai ^ bi);
            4'd6:  r = 255 - ua;
            4'd7:  begin r = ua * 2;                       cy = (ua >= 128);  aff = 4'b1011; end
            4'd8:  begin r = ua / 2;                       cy = (ua % 2 == 1); aff = 4'b1011; end
            4'd9:  begin r = ua / 2 + (ua >= 128 ? 128 : 0); cy = (ua % 2 == 1); aff = 4'b1011; end
            4'd10: begin r = ua * 2 + ci;                  cy = (ua >= 128);  aff = 4'b1011; end
            4'd11: begin r = ua / 2 + ci * 128;            cy = (ua % 2 == 1); aff = 4'b1011; end
            4'd12: r = ua + 1;
            4'd13: r = ua - 1;
            default: r = ua;
        endcase
        res = 8'(r);
        nf  = {cy, ov, res[7], res == 8'h00};
    endfunction

    logic [7:0] m_y = '0, m_yh = '0;
    logic [3:0] m_f = '0;
    logic       m_done = 1'b0, m_busy = 1'b0;
    int         m_left = 0;
    logic [7:0] mul_a = '0, mul_b = '0;
    logic [3:0] mul_we = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0]  res;
        logic [3:0]  nf, newf, aff;
        logic        wr;
        logic [15:0] p;
        if (!rst_n) begin
            m_y <= '0; m_yh <= '0; m_f <= '0; m_done <= 1'b0; m_busy <= 1'b0; m_left <= 0;
        end else begin
            nf = m_f;
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    p    = 16'(mul_a) * 16'(mul_b);
                    newf = {p[15:8] != 8'h00, 1'b0, p[15], p == 16'h0000};
                    for (int i = 0; i < 4; i++) if (mul_we[i]) nf[i] = newf[i];
                    m_y <= p[7:0]; m_yh <= p[15:8]; m_done <= 1'b1; m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                if (op == 4'hF) begin
                    m_busy <= 1'b1; m_left <= 8; mul_a <= a; mul_b <= b; mul_we <= flag_we;
                end else begin
                    model_op(op, a, b, m_f[3], res, newf, aff, wr);
                    if (wr) begin m_y <= res; m_yh <= 8'h00; end
                    for (int i = 0; i < 4; i++) if (flag_we[i] && aff[i]) nf[i] = newf[i];
                    m_done <= 1'b1;
                end
            end
            if (load_flags) nf = flags_in;
            m_f <= nf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model y", 32'(y), 32'(m_y));
            check("model yh", 32'(yh), 32'(m_yh));
            check("model flags", 32'(flags), 32'(m_f));
            check("model busy", 32'(busy), 32'(m_busy));
            check("model done", 32'(done), 32'(m_done));
        end
    end

    task automatic drive(input logic [3:0] o, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [3:0] we);
        start = 1'b1; op = o; a = ai; b = bi; flag_we = we;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [3:0] f);
        load_flags = 1'b1; flags_in = f;
        @(negedge clk);
        load_flags = 1'b0;
    endtask

    task automatic run_mul(input logic [7:0] ai, input logic [7:0] bi, input bit inject,
                           output int busy_cycles, output bit got_done);
        drive(4'hF, ai, bi, 4'hF);
        busy_cycles = 0;
        got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (inject && k == 1) begin start = 1'b1; op = 4'h0; a = 8'h01; b = 8'h01; end
                if (inject && k == 3) start = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int  bc;
        bit  gd;
        bit  seen;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flag_we = '0;
        load_flags = 1'b0; flags_in = '0; start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset y", 32'(y), 32'h0);
        check("reset yh", 32'(yh), 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);

        drive(4'd0, 8'h7F, 8'h01, 4'hF);
        check("adc y", 32'(y), 32'h80);
        check("adc flags", 32'(flags), 32'b0110);
        check("adc done", 32'(done), 32'h1);
        @(negedge clk);
        check("adc done drops", 32'(done), 32'h0);

        load(4'b1000);
        drive(4'd1, 8'h00, 8'h01, 4'hF);
        check("sbc y", 32'(y), 32'hFF);
        check("sbc flags", 32'(flags), 32'b0010);
        drive(4'd2, 8'h42, 8'h42, 4'hF);
        check("cmp flags", 32'(flags), 32'b1001);
        check("cmp y kept", 32'(y), 32'hFF);

        drive(4'd11, 8'h01, 8'h00, 4'hF);
        check("ror y", 32'(y), 32'h80);
        check("ror c", 32'(c), 32'h1);
        drive(4'd9, 8'h81, 8'h00, 4'hF);
        check("asr y", 32'(y), 32'hC0);
        check("asr c", 32'(c), 32'h1);
        drive(4'd6, 8'h0F, 8'h00, 4'hF);
        check("not y", 32'(y), 32'hF0);

        run_mul(8'hFF, 8'hFF, 1'b1, bc, gd);
        check("mul done seen", 32'(gd), 32'h1);
        check("mul busy cycles", 32'(bc), 32'd8);
        check("mul product", 32'({yh, y}), 32'hFE01);
        check("mul flags", 32'(flags), 32'b1010);
        check("mul busy low at done", 32'(busy), 32'h0);

        load(4'b0000);
        drive(4'd0, 8'h01, 8'hFF, 4'b0001);
        check("masked y", 32'(y), 32'h00);
        check("masked flags", 32'(flags), 32'b0001);

        load_flags = 1'b1; flags_in = 4'b1010;
        drive(4'd3, 8'h3C, 8'h0F, 4'hF);
        load_flags = 1'b0;
        check("ldflags y", 32'(y), 32'h0C);
        check("ldflags flags", 32'(flags), 32'b1010);

        drive(4'd12, 8'hFF, 8'h00, 4'hF);
        check("inc y", 32'(y), 32'h00);
        check("inc z", 32'(z), 32'h1);
        drive(4'd13, 8'h00, 8'h00, 4'hF);
        check("dec y", 32'(y), 32'hFF);
        drive(4'd14, 8'h5A, 8'h00, 4'hF);
        drive(4'd4, 8'h50, 8'h0A, 4'hF);
        check("or y", 32'(y), 32'h5A);
        drive(4'd5, 8'hFF, 8'h0F, 4'hF);
        check("xor y", 32'(y), 32'hF0);
        drive(4'd7, 8'h81, 8'h00, 4'hF);
        check("asl y", 32'(y), 32'h02);
        check("asl c", 32'(c), 32'h1);
        drive(4'd8, 8'h02, 8'h00, 4'hF);
        check("lsr c", 32'(c), 32'h0);
        drive(4'd10, 8'h80, 8'h00, 4'hF);
        check("rol y", 32'(y), 32'h00);
        check("rol c", 32'(c), 32'h1);
        drive(4'd1, 8'h10, 8'h01, 4'hF);
        check("sbc2 y", 32'(y), 32'h0F);
        check("back-to-back done", 32'(done), 32'h1);
        @(negedge clk);

        drive(4'hF, 8'h12, 8'h34, 4'hF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort y", 32'(y), 32'h0);
        check("abort yh", 32'(yh), 32'h0);
        check("abort flags", 32'(flags), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no done after abort", 32'(seen), 32'h0);

        run_mul(8'h03, 8'h05, 1'b0, bc, gd);
        check("mul2 done seen", 32'(gd), 32'h1);
        check("mul2 y", 32'(y), 32'h0F);
        check("mul2 yh", 32'(yh), 32'h00);
        check("mul2 busy cycles", 32'(bc), 32'd8);

        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b0;
        bc = 0;
        gd = 1'b0;
        for (int k = 0; k < 40 && !gd; k++) begin
            if (done16) gd = 1'b1;
            else begin
                if (busy16) bc++;
                @(negedge clk);
            end
        end
        check("mul16 done seen", 32'(gd), 32'h1);
        check("mul16 busy cycles", 32'(bc), 32'd16);
        check("mul16 product", {yh16, y16}, 32'hFFFE0001);
        check("mul16 flags", 32'({c16, v16, n16, z16}), 32'b1010);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
